// File: rtl/uart_pkg.sv
// uart_pkg: constants shared by the UART transmitter and receiver.
package uart_pkg;

  localparam int unsigned STATE_W    = 3;
  localparam int unsigned OVERSAMPLE = 16;

  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_START  = 3'd1;
  localparam logic [STATE_W-1:0] ST_DATA   = 3'd2;
  localparam logic [STATE_W-1:0] ST_PARITY = 3'd3;
  localparam logic [STATE_W-1:0] ST_STOP   = 3'd4;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  // 2-of-3 vote used when a bit is qualified over three oversample ticks
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: registered oversample tick every OS_DIV+1 clocks; restart realigns the phase.
module uart_baud_gen #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int unsigned OS_DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE) - 1;
  localparam int unsigned CNT_W  = (OS_DIV > 0) ? $clog2(OS_DIV + 1) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q + CNT_W'(1);
    tick_d = 1'b0;
    if (restart) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(OS_DIV)) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x oversampling UART receiver with valid/ready output, error flags and sticky overrun.
// Define UART_RX_MAJORITY_EN for a 2-of-3 vote over ticks 7..9 instead of a single tick-8 sample.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned WORD_LENGTH = 8,
  parameter string       PARITY      = "none",
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned BAUD_RATE   = 9600,
  parameter int unsigned CLK_FREQ    = 50_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_in,
  input  logic                   rx_ready,
  output logic [WORD_LENGTH-1:0] rx_data,
  output logic                   rx_valid,
  output logic                   rx_parity_err,
  output logic                   rx_frame_err,
  output logic                   rx_overrun
);

  localparam logic [1:0] PAR_MODE = (PARITY == "even") ? PAR_EVEN :
                                    (PARITY == "odd")  ? PAR_ODD  : PAR_NONE;
  localparam int unsigned BIT_W = $clog2(WORD_LENGTH + STOP_BITS + 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [3:0] SAMPLE_TICK = 4'd8;
`else
  localparam logic [3:0] SAMPLE_TICK = 4'd7;
`endif

  logic                   rx_meta_q, rx_sync_q, rx_prev_q;
  logic [1:0]             settle_q, settle_d;
  logic [STATE_W-1:0]     state_q, state_d;
  logic [3:0]             tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [WORD_LENGTH-1:0] shift_q, shift_d;
  logic                   par_err_q, par_err_d;
  logic                   frm_err_q, frm_err_d;
  logic [WORD_LENGTH-1:0] rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   rx_parity_err_q, rx_parity_err_d;
  logic                   rx_frame_err_q, rx_frame_err_d;
  logic                   rx_overrun_q, rx_overrun_d;

  logic tick;
  logic restart_c, done_c, fall_c, samp_c, bit_c, hs_c;

  uart_baud_gen #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .restart(restart_c),
    .tick   (tick)
  );

  // Edges are ignored until the synchronizer holds real line samples, so a
  // line already low when reset releases cannot fake a start bit.
  assign settle_d = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
  assign fall_c   = (settle_q == 2'd3) & rx_prev_q & ~rx_sync_q;
  assign samp_c   = tick & (tick_cnt_q == SAMPLE_TICK);

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] maj_q, maj_d;

  always_comb begin
    maj_d = maj_q;
    if (tick && (tick_cnt_q == 4'd6 || tick_cnt_q == 4'd7)) begin
      maj_d = {maj_q[0], rx_sync_q};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) maj_q <= 2'b11;
    else     maj_q <= maj_d;
  end

  assign bit_c = maj3(maj_q[1], maj_q[0], rx_sync_q);
`else
  assign bit_c = rx_sync_q;
`endif

  // Receive FSM: bit timing comes from the oversample tick count within each bit
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick ? tick_cnt_q + 4'd1 : tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_err_d  = par_err_q;
    frm_err_d  = frm_err_q;
    restart_c  = 1'b0;
    done_c     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tick_cnt_d = '0;
        if (fall_c) begin
          state_d   = ST_START;
          restart_c = 1'b1;
          bit_cnt_d = '0;
          par_err_d = 1'b0;
          frm_err_d = 1'b0;
        end
      end
      ST_START: begin
        if (samp_c) state_d = bit_c ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (samp_c) begin
          shift_d = {bit_c, shift_q[WORD_LENGTH-1:1]};
          if (bit_cnt_q == BIT_W'(WORD_LENGTH - 1)) begin
            bit_cnt_d = '0;
            state_d   = (PAR_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (samp_c) begin
          par_err_d = (^shift_q) ^ bit_c ^ (PAR_MODE == PAR_ODD);
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (samp_c) begin
          frm_err_d = frm_err_q | ~bit_c;
          if (bit_cnt_q == BIT_W'(STOP_BITS - 1)) begin
            done_c  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output holding register: a completed word loads unless an unaccepted word blocks it
  assign hs_c = rx_valid_q & rx_ready;

  always_comb begin
    rx_data_d       = rx_data_q;
    rx_valid_d      = rx_valid_q;
    rx_parity_err_d = rx_parity_err_q;
    rx_frame_err_d  = rx_frame_err_q;
    rx_overrun_d    = rx_overrun_q;
    if (hs_c) begin
      rx_valid_d   = 1'b0;
      rx_overrun_d = 1'b0;
    end
    if (done_c) begin
      if (rx_valid_q && !rx_ready) begin
        rx_overrun_d = 1'b1;
      end else begin
        rx_data_d       = shift_q;
        rx_parity_err_d = par_err_q;
        rx_frame_err_d  = frm_err_d;
        rx_valid_d      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q       <= 1'b1;
      rx_sync_q       <= 1'b1;
      rx_prev_q       <= 1'b1;
      settle_q        <= '0;
      state_q         <= ST_IDLE;
      tick_cnt_q      <= '0;
      bit_cnt_q       <= '0;
      shift_q         <= '0;
      par_err_q       <= 1'b0;
      frm_err_q       <= 1'b0;
      rx_data_q       <= '0;
      rx_valid_q      <= 1'b0;
      rx_parity_err_q <= 1'b0;
      rx_frame_err_q  <= 1'b0;
      rx_overrun_q    <= 1'b0;
    end else begin
      rx_meta_q       <= rx_in;
      rx_sync_q       <= rx_meta_q;
      rx_prev_q       <= rx_sync_q;
      settle_q        <= settle_d;
      state_q         <= state_d;
      tick_cnt_q      <= tick_cnt_d;
      bit_cnt_q       <= bit_cnt_d;
      shift_q         <= shift_d;
      par_err_q       <= par_err_d;
      frm_err_q       <= frm_err_d;
      rx_data_q       <= rx_data_d;
      rx_valid_q      <= rx_valid_d;
      rx_parity_err_q <= rx_parity_err_d;
      rx_frame_err_q  <= rx_frame_err_d;
      rx_overrun_q    <= rx_overrun_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = rx_parity_err_q;
  assign rx_frame_err  = rx_frame_err_q;
  assign rx_overrun    = rx_overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed plus randomized frames on two receivers (no parity / 1 stop, even parity / 2 stops).
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int unsigned CLK_FREQ = 16_000_000;
  localparam int unsigned BAUD     = 1_000_000;
  localparam int          BIT_CLKS = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_a, rx_b;
  logic       rx_ready_a, rx_ready_b;
  logic [7:0] rx_data_a, rx_data_b;
  logic       rx_valid_a, rx_valid_b;
  logic       rx_parity_err_a, rx_parity_err_b;
  logic       rx_frame_err_a, rx_frame_err_b;
  logic       rx_overrun_a, rx_overrun_b;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int hi_a    = 0;
  logic [9:0] q_a[$];
  logic [9:0] q_b[$];

  always #5 clk = ~clk;

  uart_rx #(.WORD_LENGTH(8), .PARITY("none"), .STOP_BITS(1),
            .BAUD_RATE(BAUD), .CLK_FREQ(CLK_FREQ)) dut_a (
    .clk(clk), .rst(rst), .rx_in(rx_a), .rx_ready(rx_ready_a),
    .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_parity_err(rx_parity_err_a),
    .rx_frame_err(rx_frame_err_a), .rx_overrun(rx_overrun_a));

  uart_rx #(.WORD_LENGTH(8), .PARITY("even"), .STOP_BITS(2),
            .BAUD_RATE(BAUD), .CLK_FREQ(CLK_FREQ)) dut_b (
    .clk(clk), .rst(rst), .rx_in(rx_b), .rx_ready(rx_ready_b),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_parity_err(rx_parity_err_b),
    .rx_frame_err(rx_frame_err_b), .rx_overrun(rx_overrun_b));

  // Collect every accepted word as {parity_err, frame_err, data}
  always @(negedge clk) begin
    if (!rst && rx_valid_a) hi_a++;
    if (!rst && rx_valid_a && rx_ready_a) q_a.push_back({rx_parity_err_a, rx_frame_err_a, rx_data_a});
    if (!rst && rx_valid_b && rx_ready_b) q_b.push_back({rx_parity_err_b, rx_frame_err_b, rx_data_b});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference frame: start 0, data LSB first, optional parity bit, stop bits
  function automatic logic [15:0] build_frame(input logic [7:0] d, input bit par_en,
                                              input bit bad_par, input int stops,
                                              input logic [1:0] stop_vals);
    logic [15:0] f;
    int k;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = d[i];
    k = 9;
    if (par_en) begin
      f[k] = (^d) ^ bad_par;
      k++;
    end
    for (int s = 0; s < stops; s++) f[k+s] = stop_vals[s];
    return f;
  endfunction

  function automatic logic [9:0] exp_word(input logic [7:0] d, input bit par_en, input bit bad_par,
                                          input int stops, input logic [1:0] stop_vals);
    logic ferr;
    ferr = 1'b0;
    for (int s = 0; s < stops; s++) if (!stop_vals[s]) ferr = 1'b1;
    return {par_en & bad_par, ferr, d};
  endfunction

  task automatic set_line(input int which, input logic v);
    if (which == 0) rx_a = v;
    else            rx_b = v;
  endtask

  task automatic send_bits(input int which, input logic [15:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      set_line(which, f[i]);
      repeat (BIT_CLKS) @(posedge clk);
      #1;
    end
    set_line(which, 1'b1);
  endtask

  task automatic send_frame(input int which, input logic [7:0] d, input bit bad_par,
                            input logic [1:0] stop_vals);
    bit par_en;
    int stops;
    par_en = (which == 1);
    stops  = (which == 1) ? 2 : 1;
    send_bits(which, build_frame(d, par_en, bad_par, stops, stop_vals), 9 + int'(par_en) + stops);
    repeat (3 * BIT_CLKS) @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input string tag, input int which, input logic [9:0] exp);
    logic [9:0] got;
    int n;
    @(negedge clk);
    n = (which == 0) ? q_a.size() : q_b.size();
    chk({tag, " count"}, 32'(n), 32'd1);
    if (n > 0) begin
      if (which == 0) got = q_a.pop_front();
      else            got = q_b.pop_front();
      chk({tag, " data"}, 32'(got[7:0]), 32'(exp[7:0]));
      chk({tag, " parity_err"}, 32'(got[9]), 32'(exp[9]));
      chk({tag, " frame_err"}, 32'(got[8]), 32'(exp[8]));
    end
    q_a.delete();
    q_b.delete();
  endtask

  initial begin
    logic [7:0] d;
    bit bad;
    int h0;
    rst = 1'b1; rx_a = 1'b1; rx_b = 1'b1; rx_ready_a = 1'b1; rx_ready_b = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset valid", 32'(rx_valid_a), 32'd0);
    chk("reset data", 32'(rx_data_a), 32'd0);
    chk("reset parity_err", 32'(rx_parity_err_a), 32'd0);
    chk("reset frame_err", 32'(rx_frame_err_a), 32'd0);
    chk("reset overrun", 32'(rx_overrun_a), 32'd0);
    chk("reset valid b", 32'(rx_valid_b), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;

    h0 = hi_a;
    send_frame(0, 8'hA5, 1'b0, 2'b11);
    expect_word("a5 frame", 0, exp_word(8'hA5, 1'b0, 1'b0, 1, 2'b11));
    chk("a5 valid pulse clks", 32'(hi_a - h0), 32'd1);
    chk("a5 valid low after", 32'(rx_valid_a), 32'd0);

    send_frame(1, 8'h07, 1'b1, 2'b11);
    expect_word("even 07 bad parity", 1, exp_word(8'h07, 1'b1, 1'b1, 2, 2'b11));
    send_frame(1, 8'h96, 1'b0, 2'b01);
    expect_word("even second stop low", 1, exp_word(8'h96, 1'b1, 1'b0, 2, 2'b01));

    send_frame(0, 8'hE1, 1'b0, 2'b10);
    expect_word("stop low", 0, exp_word(8'hE1, 1'b0, 1'b0, 1, 2'b10));
    send_frame(0, 8'h3C, 1'b0, 2'b11);
    expect_word("3c after frame err", 0, exp_word(8'h3C, 1'b0, 1'b0, 1, 2'b11));

    h0 = hi_a;
    @(posedge clk); #1 rx_a = 1'b0;
    repeat (8) @(posedge clk);
    #1 rx_a = 1'b1;
    repeat (60) @(posedge clk);
    @(negedge clk);
    chk("glitch valid", 32'(rx_valid_a), 32'd0);
    chk("glitch no word", 32'(hi_a - h0), 32'd0);
    #1;

    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom);
      send_frame(0, d, 1'b0, 2'b11);
      expect_word("random none", 0, exp_word(d, 1'b0, 1'b0, 1, 2'b11));
      d   = 8'($urandom);
      bad = ($urandom_range(0, 3) == 0);
      send_frame(1, d, bad, 2'b11);
      expect_word("random even", 1, exp_word(d, 1'b1, bad, 2, 2'b11));
      repeat ($urandom_range(1, 20)) @(posedge clk);
      #1;
    end

    rx_ready_a = 1'b0;
    send_frame(0, 8'h11, 1'b0, 2'b11);
    send_frame(0, 8'h22, 1'b0, 2'b11);
    @(negedge clk);
    chk("overrun valid held", 32'(rx_valid_a), 32'd1);
    chk("overrun data kept", 32'(rx_data_a), 32'h11);
    chk("overrun flag", 32'(rx_overrun_a), 32'd1);
    @(posedge clk); #1 rx_ready_a = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("handshake clears valid", 32'(rx_valid_a), 32'd0);
    chk("handshake clears overrun", 32'(rx_overrun_a), 32'd0);
    chk("handshake word count", 32'(q_a.size()), 32'd1);
    if (q_a.size() > 0) chk("handshake word", 32'(q_a[0]), 32'(exp_word(8'h11, 1'b0, 1'b0, 1, 2'b11)));
    q_a.delete();
    #1;

    fork
      send_bits(0, build_frame(8'hC3, 1'b0, 1'b0, 1, 2'b11), 10);
      begin
        repeat (5 * BIT_CLKS + 8) @(posedge clk);
        #1 rst = 1'b1;
        repeat (20) @(posedge clk);
        #1 rst = 1'b0;
      end
    join
    repeat (3 * BIT_CLKS) @(posedge clk);
    @(negedge clk);
    chk("reset mid frame no word", 32'(q_a.size()), 32'd0);
    chk("reset mid frame valid", 32'(rx_valid_a), 32'd0);
    #1;
    send_frame(0, 8'h5A, 1'b0, 2'b11);
    expect_word("5a after reset", 0, exp_word(8'h5A, 1'b0, 1'b0, 1, 2'b11));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter WORD_LENGTH, default 8, data bits per frame.
REQ-002 SHALL have parameter PARITY, default "none", one of "none"/"even"/"odd".
REQ-003 SHALL have parameter STOP_BITS, default 1, stop bits checked per frame (1 or 2).
REQ-004 SHALL have parameter BAUD_RATE, default 9600, line bit rate in Hz.
REQ-005 SHALL have parameter CLK_FREQ, default 50_000_000, clk frequency in Hz.
REQ-006 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port rx_in  input  1  serial line, asynchronous to clk, idle high.
REQ-009 SHALL have port rx_ready  input  1  consumer accepts rx_data when high with rx_valid.
REQ-010 SHALL have port rx_data  output  WORD_LENGTH  received word, LSB received first.
REQ-011 SHALL have port rx_valid  output  1  rx_data holds an unaccepted word.
REQ-012 SHALL have port rx_parity_err  output  1  parity mismatch for the word in rx_data.
REQ-013 SHALL have port rx_frame_err  output  1  a stop bit sampled low for the word in rx_data.
REQ-014 SHALL have port rx_overrun  output  1  sticky, a completed word was dropped.

Function
REQ-015 SHALL pass rx_in through a 2-flop synchronizer before any use; both flops reset to 1.
REQ-016 SHALL generate a 16x oversample tick every OS_DIV+1 clocks, OS_DIV = CLK_FREQ/(BAUD_RATE*16) - 1 (integer division), counter restarts on every IDLE->START transition.
REQ-017 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-018 IDLE -> START SHALL occur on a synchronized high-to-low transition of rx_in.
REQ-019 In START, at the 8th tick (mid-bit), SHALL go to DATA if line low, else return to IDLE (false start, no output change).
REQ-020 In DATA SHALL sample every 16 ticks, shifting bits LSB-first; after WORD_LENGTH samples SHALL go to PARITY if PARITY != "none", else STOP.
REQ-021 In PARITY SHALL sample one bit; error if (^data ^ bit) != 0 for "even", == 0 for "odd".
REQ-022 In STOP SHALL sample STOP_BITS bits 16 ticks apart; any low sample sets the frame error; after the last sample SHALL go to IDLE immediately (mid-stop-bit) to allow resync.
REQ-023 On leaving STOP SHALL, in the same clock, load rx_data, rx_parity_err, rx_frame_err and set rx_valid, unless rx_valid=1 and rx_ready=0.
REQ-024 rx_valid SHALL clear on the clock where rx_valid & rx_ready, unless a new word loads the same clock (then rx_valid stays 1 with new data).
REQ-025 A completing word with rx_valid=1 and rx_ready=0 SHALL be dropped, output registers unchanged, rx_overrun set to 1.
REQ-026 rx_overrun SHALL clear only on the next rx_valid & rx_ready handshake.
REQ-027 Latency: rx_valid SHALL rise within 2 clocks after the final stop-bit sample tick.
REQ-028 A frame with frame error SHALL still be delivered (data plus rx_frame_err=1).

Reset
REQ-029 On rst SHALL immediately set state IDLE, rx_data 0, rx_valid 0, rx_parity_err 0, rx_frame_err 0, rx_overrun 0, counters 0.
REQ-030 Reset released mid-frame SHALL discard the frame and require a fresh falling edge.

Configuration
REQ-031 With UART_RX_MAJORITY_EN defined, each bit SHALL be the 2-of-3 majority of ticks 7, 8, 9 of that bit (START qualified the same way).
REQ-032 Without UART_RX_MAJORITY_EN, each bit SHALL be the single sample at tick 8.

Structure
REQ-033 State encoding and the parity-mode constants SHALL live in shared package uart_pkg, used by uart_tx and uart_rx.
REQ-034 The oversample tick generator SHALL be sub-module uart_baud_gen (params CLK_FREQ, BAUD_RATE, OVERSAMPLE), reusable by the transmitter.

Verification (CLK_FREQ=16_000_000, BAUD_RATE=1_000_000, bit = 16 clks)
REQ-035 Frame 0x A5, PARITY none, rx_ready=1 -> rx_valid pulse 1 clk, rx_data=0xA5, errors 0.
REQ-036 PARITY "even", frame 0x07 with parity bit 0 -> rx_data=0x07, rx_parity_err=1.
REQ-037 Stop bit driven low -> rx_frame_err=1, data still delivered; next frame 0x3C received correctly.
REQ-038 8-clk low glitch on idle line -> returns to IDLE, rx_valid stays 0.
REQ-039 rx_ready=0, frames 0x11 then 0x22 -> rx_data=0x11, rx_overrun=1; handshake clears both.
REQ-040 rst asserted at bit 4 of frame, released, then frame 0x5A -> only 0x5A delivered, no errors.
